// File: rtl/pcie_buf_scheduler_pkg.sv
// nysa_pcie_defines: shared state, direction and buffer-index encodings for the PCIe buffer scheduler.
package nysa_pcie_defines;
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      CHECK     = 4'd1,
      WAIT_BUF  = 4'd2,
      ISSUE     = 4'd3,
      WAIT_DONE = 4'd4,
      STATUS    = 4'd5,
      DONE      = 4'd6
   } state_t;
   localparam logic DIR_H2D = 1'b0;
   localparam logic DIR_D2H = 1'b1;
   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;
endpackage

// File: rtl/pcie_buf_scheduler_if.sv
// pcie_buf_scheduler_if: command, host-buffer, DMA request and status signals of the scheduler.
interface pcie_buf_scheduler_if;
   logic        i_cmd_wr_stb, i_cmd_rd_stb, i_cmd_rst_stb;
   logic [31:0] i_cmd_data_count, i_buffer_size;
   logic [31:0] i_write_a_addr, i_write_b_addr, i_read_a_addr, i_read_b_addr;
   logic        i_update_buf_stb;
   logic [1:0]  i_update_buf;
   logic        o_dma_req_valid, i_dma_req_ready, o_dma_dir;
   logic [31:0] o_dma_addr, o_dma_len;
   logic        i_dma_done;
   logic        o_status_stb, o_status_buf, o_cmd_done_stb, o_cmd_error_stb, o_busy;
   logic [1:0]  o_buf_ready;
   logic [3:0]  o_state;
   modport slave (
      input  i_cmd_wr_stb, i_cmd_rd_stb, i_cmd_rst_stb, i_cmd_data_count, i_buffer_size,
             i_write_a_addr, i_write_b_addr, i_read_a_addr, i_read_b_addr,
             i_update_buf_stb, i_update_buf, i_dma_req_ready, i_dma_done,
      output o_dma_req_valid, o_dma_dir, o_dma_addr, o_dma_len, o_status_stb, o_status_buf,
             o_cmd_done_stb, o_cmd_error_stb, o_busy, o_buf_ready, o_state
   );
   modport master (
      output i_cmd_wr_stb, i_cmd_rd_stb, i_cmd_rst_stb, i_cmd_data_count, i_buffer_size,
             i_write_a_addr, i_write_b_addr, i_read_a_addr, i_read_b_addr,
             i_update_buf_stb, i_update_buf, i_dma_req_ready, i_dma_done,
      input  o_dma_req_valid, o_dma_dir, o_dma_addr, o_dma_len, o_status_stb, o_status_buf,
             o_cmd_done_stb, o_cmd_error_stb, o_busy, o_buf_ready, o_state
   );
endinterface

// File: rtl/pcie_buf_scheduler_flags.sv
// pcie_buf_flags: host buffer-ready flags; clear beats set, set beats consume.
module pcie_buf_flags (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [1:0] consume,
   input  logic       set_stb,
   input  logic [1:0] set,
   output logic [1:0] flags
);
   always_ff @(posedge clk)
      if (!rst || clr) flags <= '0;
      else flags <= (flags & ~consume) | (set_stb ? set : 2'b00);
endmodule

// File: rtl/pcie_buf_scheduler.sv
// pcie_buf_scheduler: splits commands into buffer-sized chunks ping-ponged over host buffers A/B.
// Optional buffer-wait watchdog enabled by PCIE_BUF_SCHED_TIMEOUT_EN.
module pcie_buf_scheduler
   import nysa_pcie_defines::*;
`ifdef PCIE_BUF_SCHED_TIMEOUT_EN
   #(parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000)
`endif
   (
   input logic clk,
   input logic rst,
   pcie_buf_scheduler_if.slave bus
);
   state_t state, nxt;
   logic r_dir, r_sel, rdy, tmo, start;
   logic [31:0] r_remaining, r_bufsize, r_addr, r_len;
   logic [1:0] flags, consume;
   assign rdy = flags[r_sel];
   assign start = bus.i_cmd_wr_stb || bus.i_cmd_rd_stb;
`ifdef PCIE_BUF_SCHED_TIMEOUT_EN
   logic [31:0] cnt;
   assign tmo = (state == WAIT_BUF) && (cnt == TIMEOUT_CYCLES - 32'd1);
   always_ff @(posedge clk)
      if (!rst || state != WAIT_BUF || nxt != WAIT_BUF) cnt <= '0;
      else cnt <= cnt + 32'd1;
`else
   assign tmo = 1'b0;
`endif
   pcie_buf_flags u_flags (
      .clk(clk), .rst(rst), .clr(bus.i_cmd_rst_stb), .consume(consume),
      .set_stb(bus.i_update_buf_stb), .set(bus.i_update_buf), .flags(flags)
   );
   always_comb begin
      nxt = state;
      consume = 2'b00;
      case (state)
         IDLE:      nxt = start ? CHECK : IDLE;
         CHECK:     nxt = (r_bufsize == 0) ? IDLE : (r_remaining == 0) ? DONE : WAIT_BUF;
         WAIT_BUF: begin
            if (rdy) begin
               nxt = ISSUE;
               consume[r_sel] = 1'b1;
            end else if (tmo) nxt = IDLE;
         end
         ISSUE:     nxt = bus.i_dma_req_ready ? WAIT_DONE : ISSUE;
         WAIT_DONE: nxt = bus.i_dma_done ? STATUS : WAIT_DONE;
         STATUS:    nxt = CHECK;
         default:   nxt = IDLE;
      endcase
      if (bus.i_cmd_rst_stb) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         r_dir <= DIR_H2D;
         r_sel <= BUF_A;
         r_remaining <= '0;
         r_bufsize <= '0;
         r_addr <= '0;
         r_len <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            r_dir <= bus.i_cmd_wr_stb ? DIR_H2D : DIR_D2H;
            r_remaining <= bus.i_cmd_data_count;
            r_bufsize <= bus.i_buffer_size;
            r_sel <= BUF_A;
         end
         if (state == WAIT_BUF && rdy) begin
            r_len <= (r_remaining < r_bufsize) ? r_remaining : r_bufsize;
            r_addr <= r_dir ? (r_sel ? bus.i_read_b_addr : bus.i_read_a_addr)
                            : (r_sel ? bus.i_write_b_addr : bus.i_write_a_addr);
         end
         if (state == STATUS) begin
            r_remaining <= r_remaining - r_len;
            r_sel <= ~r_sel;
         end
      end
   end
   assign bus.o_dma_req_valid = state == ISSUE;
   assign bus.o_dma_dir = (state == ISSUE) && r_dir;
   assign bus.o_dma_addr = (state == ISSUE) ? r_addr : '0;
   assign bus.o_dma_len = (state == ISSUE) ? r_len : '0;
   assign bus.o_status_stb = state == STATUS;
   assign bus.o_status_buf = (state == STATUS) && r_sel;
   assign bus.o_cmd_done_stb = state == DONE;
   assign bus.o_cmd_error_stb = ((state == CHECK) && (r_bufsize == 0)) || ((state == WAIT_BUF) && !rdy && tmo);
   assign bus.o_busy = state != IDLE;
   assign bus.o_buf_ready = flags;
   assign bus.o_state = state;
endmodule
